// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
//   A shared Galois-free (shift-left, XNOR feedback) LFSR that serves random
//   words to NUM_REQ requesters. An idle request is arbitrated round-robin,
//   the LFSR is stepped STEPS times, and the resulting word is presented to
//   the winner until it is accepted or the winner withdraws its request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | accept seed loads, arbitrate pending requests
// RUN     | shift the LFSR once per cycle, STEPS shifts in total
// DELIVER | word presented to the winner, LFSR frozen
//
// Ports
//   i_Clk          clock, rising edge
//   i_Rst_n        synchronous active-low reset
//   i_Seed_DV      seed load strobe (honoured only in IDLE, non all-ones)
//   i_Seed_Data    seed value
//   i_Req          per-requester request level
//   i_Ack          winner accepts the presented word
//   o_Gnt          one-hot grant, only while o_Rand_Valid
//   o_Rand_Valid   o_Rand_Data valid for the granted requester
//   o_Rand_Data    random word (zero outside DELIVER)
//   o_Busy         FSM not in IDLE
//   o_Seed_Err     one-cycle pulse after a rejected seed strobe
//   o_Period_Done  one-cycle pulse after a shift lands on the loaded seed
module lfsr_rng_arbiter #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   TAPS    = 16'hD008,
    parameter int                 NUM_REQ = 4,
    parameter int                 STEPS   = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Seed_DV,
    input  logic [WIDTH-1:0]   i_Seed_Data,
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic               i_Ack,
    output logic [NUM_REQ-1:0] o_Gnt,
    output logic               o_Rand_Valid,
    output logic [WIDTH-1:0]   o_Rand_Data,
    output logic               o_Busy,
    output logic               o_Seed_Err,
    output logic               o_Period_Done
);

    localparam int             IW        = $clog2(NUM_REQ);
    localparam logic [IW:0]    NREQ      = (IW+1)'(NUM_REQ);
    localparam logic [7:0]     LAST_STEP = 8'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DELIVER} fsm_t;

    fsm_t               fsm;
    logic [WIDTH-1:0]   lfsr;
    logic [WIDTH-1:0]   seed_q;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      winner;
    logic [7:0]         cnt;

    logic               fb;
    logic [WIDTH-1:0]   lfsr_next;
    logic               seed_ok;
    logic               seed_bad;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0] req_rot;
    logic               pick_valid;
    logic [IW-1:0]      pick;
    logic [IW:0]        pick_sum;
    logic [IW:0]        ptr_sum;
    logic [IW-1:0]      ptr_next;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_held;

    // XNOR feedback makes all-zeros a legal state and all-ones the lockup.
    assign fb        = ~^(lfsr & TAPS);
    assign lfsr_next = {lfsr[WIDTH-2:0], fb};

    assign seed_ok   = i_Seed_DV && (fsm == IDLE) && (i_Seed_Data != '1);
    assign seed_bad  = i_Seed_DV && !seed_ok;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit of
    // the rotated vector is the round-robin winner.
    assign req_dbl = {i_Req, i_Req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        pick_sum   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_valid = 1'b1;
                pick_sum   = {1'b0, ptr} + (IW+1)'(i);
                pick       = (pick_sum >= NREQ) ? IW'(pick_sum - NREQ) : IW'(pick_sum);
            end
        end
    end

    assign ptr_sum  = {1'b0, winner} + (IW+1)'(1);
    assign ptr_next = (ptr_sum == NREQ) ? '0 : ptr_sum[IW-1:0];

    assign win_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
    assign win_held = |(i_Req & win_oh);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            fsm           <= IDLE;
            lfsr          <= '0;
            seed_q        <= '0;
            ptr           <= '0;
            winner        <= '0;
            cnt           <= '0;
            o_Gnt         <= '0;
            o_Rand_Valid  <= 1'b0;
            o_Rand_Data   <= '0;
            o_Busy        <= 1'b0;
            o_Seed_Err    <= 1'b0;
            o_Period_Done <= 1'b0;
        end else begin
            o_Seed_Err    <= seed_bad;
            o_Period_Done <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (seed_ok) begin
                        lfsr   <= i_Seed_Data;
                        seed_q <= i_Seed_Data;
                    end else if (pick_valid) begin
                        winner <= pick;
                        cnt    <= '0;
                        fsm    <= RUN;
                        o_Busy <= 1'b1;
                    end
                end
                RUN: begin
                    lfsr          <= lfsr_next;
                    cnt           <= cnt + 8'd1;
                    o_Period_Done <= (lfsr_next == seed_q);
                    if (cnt == LAST_STEP) begin
                        fsm          <= DELIVER;
                        o_Rand_Valid <= 1'b1;
                        o_Gnt        <= win_oh;
                        o_Rand_Data  <= lfsr_next;
                    end
                end
                DELIVER: begin
                    // Accepted or abandoned: either way the pointer moves on.
                    if (i_Ack || !win_held) begin
                        fsm          <= IDLE;
                        ptr          <= ptr_next;
                        o_Busy       <= 1'b0;
                        o_Rand_Valid <= 1'b0;
                        o_Gnt        <= '0;
                        o_Rand_Data  <= '0;
                    end
                end
                default: begin
                    fsm    <= IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Testbench for lfsr_rng_arbiter (WIDTH=4, TAPS=4'hC, NUM_REQ=4).
// Main instance uses STEPS=1; a second instance uses STEPS=4 for the
// reset-during-RUN scenario.
module tb_lfsr_rng_arbiter;

    localparam logic [3:0] TAPS_TB = 4'hC;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, seed_dv, ack;
    logic [3:0] seed_data, req;
    logic [3:0] gnt, data;
    logic       valid, busy, seed_err, pdone;

    logic       rst4_n, seed4_dv, ack4;
    logic [3:0] seed4_data, req4;
    logic [3:0] gnt4, data4;
    logic       valid4, busy4, seed4_err, pdone4;

    lfsr_rng_arbiter #(.WIDTH(4), .TAPS(4'hC), .NUM_REQ(4), .STEPS(1)) u_dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Seed_DV(seed_dv), .i_Seed_Data(seed_data),
        .i_Req(req), .i_Ack(ack), .o_Gnt(gnt), .o_Rand_Valid(valid),
        .o_Rand_Data(data), .o_Busy(busy), .o_Seed_Err(seed_err),
        .o_Period_Done(pdone)
    );

    lfsr_rng_arbiter #(.WIDTH(4), .TAPS(4'hC), .NUM_REQ(4), .STEPS(4)) u_dut4 (
        .i_Clk(clk), .i_Rst_n(rst4_n), .i_Seed_DV(seed4_dv), .i_Seed_Data(seed4_data),
        .i_Req(req4), .i_Ack(ack4), .o_Gnt(gnt4), .o_Rand_Valid(valid4),
        .o_Rand_Data(data4), .o_Busy(busy4), .o_Seed_Err(seed4_err),
        .o_Period_Done(pdone4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: LFSR value, loaded seed, round-robin pointer.
    logic [3:0] m_state, m_seed;
    int         m_ptr;

    function automatic logic [3:0] m_step(input logic [3:0] s);
        int ones;
        int fb;
        ones = $countones(s & TAPS_TB);
        fb   = (ones % 2 == 0) ? 1 : 0;
        return 4'(((int'(s) * 2) % 16) + fb);
    endfunction

    function automatic int m_arb(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            int idx = (m_ptr + k) % 4;
            if (((r >> idx) & 4'd1) != 4'd0) return idx;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
        chk({tag, "_gnt"},   32'(gnt),   32'd0);
        chk({tag, "_data"},  32'(data),  32'd0);
    endtask

    task automatic model_reset;
        m_state = 4'h0;
        m_seed  = 4'h0;
        m_ptr   = 0;
    endtask

    // One request/deliver transaction on the STEPS=1 instance.
    task automatic txn(input logic [3:0] r, input bit drop, input bit seed_run,
                       output logic [3:0] got);
        int         w;
        logic [3:0] oh;
        w   = m_arb(r);
        oh  = 4'(1 << w);
        req = r;
        tick;
        chk("run_busy",  32'(busy),  32'd1);
        chk("run_valid", 32'(valid), 32'd0);
        // Requests wiggle during RUN; the latched winner must not change.
        req = 4'($urandom_range(0, 15));
        if (seed_run) begin
            seed_dv   = 1'b1;
            seed_data = 4'($urandom_range(0, 14));
        end
        tick;
        if (seed_run) begin
            seed_dv = 1'b0;
            chk("seed_err_run", 32'(seed_err), 32'd1);
        end
        m_state = m_step(m_state);
        chk("period_done", 32'(pdone), 32'(m_state == m_seed));
        chk("dlv_valid", 32'(valid), 32'd1);
        chk("dlv_gnt",   32'(gnt),   32'(oh));
        chk("dlv_data",  32'(data),  32'(m_state));
        got = data;
        if (drop) begin
            req = r & ~oh;
            ack = 1'b0;
        end else begin
            req = r;
            ack = 1'b1;
        end
        tick;
        ack = 1'b0;
        req = 4'h0;
        chk_idle("post_dlv");
        m_ptr = (w + 1) % 4;
    endtask

    task automatic seed_load(input logic [3:0] v, input bit with_req);
        seed_dv   = 1'b1;
        seed_data = v;
        if (with_req && v != 4'hF) req = 4'($urandom_range(1, 15));
        tick;
        seed_dv = 1'b0;
        req     = 4'h0;
        chk("seed_err", 32'(seed_err), 32'(v == 4'hF));
        chk("seed_busy", 32'(busy), 32'd0);
        if (v != 4'hF) begin
            m_state = v;
            m_seed  = v;
        end
        tick;
        chk("seed_err_clr", 32'(seed_err), 32'd0);
    endtask

    logic [3:0] seq [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                             4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] got;
        logic [3:0] m4;

        rst_n = 1'b0; seed_dv = 1'b0; seed_data = 4'h0; req = 4'h0; ack = 1'b0;
        rst4_n = 1'b0; seed4_dv = 1'b0; seed4_data = 4'h0; req4 = 4'h0; ack4 = 1'b0;
        model_reset();
        tick;
        tick;
        chk_idle("reset");
        chk("reset_seed_err", 32'(seed_err), 32'd0);
        chk("reset_pdone",    32'(pdone),    32'd0);
        rst_n = 1'b1;
        tick;
        chk_idle("release");

        // Directed: first grants from reset, pointer rotation.
        txn(4'b0100, 1'b0, 1'b0, got);
        chk("first_word", 32'(got), 32'h1);
        txn(4'b0101, 1'b0, 1'b0, got);
        chk("rr_word_a", 32'(got), 32'h3);
        txn(4'b0101, 1'b0, 1'b0, got);
        chk("rr_word_b", 32'(got), 32'h7);

        // All-ones seed is rejected; seed during RUN is rejected.
        seed_load(4'hF, 1'b0);
        txn(4'b0001, 1'b0, 1'b1, got);
        chk("after_bad_seed", 32'(got), 32'hE);

        // Full period from seed 0 (seed wins over a simultaneous request).
        seed_load(4'h0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            txn(4'($urandom_range(1, 15)), 1'b0, 1'b0, got);
            chk("period_seq", 32'(got), 32'(seq[i]));
        end

        // Winner withdraws without ack; LFSR keeps the delivered value.
        txn(4'($urandom_range(1, 15)), 1'b1, 1'b0, got);
        txn(4'($urandom_range(1, 15)), 1'b0, 1'b0, got);

        // Reset while in DELIVER.
        req = 4'b1111;
        tick;
        tick;
        chk("pre_rst_valid", 32'(valid), 32'd1);
        rst_n = 1'b0;
        tick;
        chk_idle("rst_dlv");
        chk("rst_dlv_pdone", 32'(pdone), 32'd0);
        rst_n = 1'b1;
        req   = 4'h0;
        model_reset();
        tick;
        chk_idle("rst_dlv_rel");
        txn(4'b1111, 1'b0, 1'b0, got);
        chk("rst_dlv_word", 32'(got), 32'h1);

        // Randomised mix of seeds, drops, run-time seed strobes.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 2) begin
                seed_load(($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            end else begin
                txn(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), got);
            end
        end

        // STEPS=4 instance: reset in the second RUN cycle.
        rst4_n = 1'b1;
        tick;
        req4 = 4'b0001;
        tick;
        chk("s4_run_busy", 32'(busy4), 32'd1);
        tick;
        rst4_n = 1'b0;
        tick;
        chk("s4_rst_busy",  32'(busy4),     32'd0);
        chk("s4_rst_valid", 32'(valid4),    32'd0);
        chk("s4_rst_gnt",   32'(gnt4),      32'd0);
        chk("s4_rst_data",  32'(data4),     32'd0);
        chk("s4_rst_serr",  32'(seed4_err), 32'd0);
        chk("s4_rst_pdone", 32'(pdone4),    32'd0);
        rst4_n = 1'b1;
        req4   = 4'h0;
        tick;
        chk("s4_rel_busy", 32'(busy4), 32'd0);
        m4 = 4'h0;
        for (int k = 0; k < 4; k++) m4 = m_step(m4);
        req4 = 4'b0010;
        tick;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("s4_early_valid", 32'(valid4), 32'd0);
        end
        tick;
        chk("s4_valid", 32'(valid4), 32'd1);
        chk("s4_gnt",   32'(gnt4),   32'b0010);
        chk("s4_data",  32'(data4),  32'(m4));
        ack4 = 1'b1;
        tick;
        ack4 = 1'b0;
        req4 = 4'h0;
        chk("s4_done_busy",  32'(busy4),  32'd0);
        chk("s4_done_valid", 32'(valid4), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
